// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the Elpis branch predictor: counter encodings,
// FSM state encodings and default table size.
package branch_predictor_pkg;

    // Default log2 of the counter-table depth.
    localparam int unsigned ENTRIES_LOG2_DEFAULT = 6;

    typedef logic [1:0] counter_t;

    // 2-bit saturating counter states.
    localparam counter_t CNT_SNT = 2'b00;  // strongly not-taken
    localparam counter_t CNT_WNT = 2'b01;  // weakly not-taken
    localparam counter_t CNT_WT  = 2'b10;  // weakly taken
    localparam counter_t CNT_ST  = 2'b11;  // strongly taken

    // FSM state encodings.
    localparam logic [0:0] BP_STATE_INIT = 1'b0;
    localparam logic [0:0] BP_STATE_RUN  = 1'b1;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational next-state for a 2-bit saturating counter: count up on
// taken, down on not-taken, holding at the 00 and 11 end points.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] value,
    input  logic       taken,
    output logic [1:0] next_value
);

    // Saturating increment or decrement.
    always_comb begin
        next_value = value;
        if (taken) begin
            if (value != CNT_ST) begin
                next_value = value + 2'b01;
            end
        end else begin
            if (value != CNT_SNT) begin
                next_value = value - 2'b01;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Per-PC dynamic branch predictor: a table of 2-bit saturating counters
// trained by resolved conditional branches from execute, answering taken
// predictions to fetch one cycle after the request. After reset an init
// walk writes RESET_COUNTER into every entry, one per cycle.
//
// Optional build macro BRANCH_PREDICTOR_GSHARE_EN: XORs a non-speculative
// global history register into both predict and update indices.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES_LOG2  = ENTRIES_LOG2_DEFAULT,
    parameter logic [1:0]  RESET_COUNTER = CNT_WNT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready_out,
    input  logic        predict_valid_in,
    input  logic [31:0] predict_pc_in,
    output logic        predict_valid_out,
    output logic        predict_taken_out,
    input  logic        update_valid_in,
    input  logic [31:0] update_pc_in,
    input  logic        update_taken_in
);

    localparam int unsigned DEPTH = 1 << ENTRIES_LOG2;

    logic [0:0]              state_q;
    logic [ENTRIES_LOG2-1:0] idx_q;
    logic                    ready_q;
    logic                    pred_valid_q;
    logic                    pred_taken_q;
    logic [1:0]              counter_q [DEPTH];

    logic                    run;
    logic [ENTRIES_LOG2-1:0] pred_idx;
    logic [ENTRIES_LOG2-1:0] upd_idx;
    logic [1:0]              upd_cur;
    logic [1:0]              upd_next;

    // PC bits outside the index field are intentionally dropped (aliasing).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{predict_pc_in[31:ENTRIES_LOG2+2], predict_pc_in[1:0],
                              update_pc_in[31:ENTRIES_LOG2+2], update_pc_in[1:0]};

    assign run = (state_q == BP_STATE_RUN);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [ENTRIES_LOG2-1:0] history_q;

    // Global history shifts in each committed outcome; frozen during init.
    always_ff @(posedge clk) begin
        if (reset) begin
            history_q <= '0;
        end else if (run && update_valid_in) begin
            history_q <= {history_q[ENTRIES_LOG2-2:0], update_taken_in};
        end
    end

    // Both indices use the pre-shift history.
    assign pred_idx = predict_pc_in[ENTRIES_LOG2+1:2] ^ history_q;
    assign upd_idx  = update_pc_in[ENTRIES_LOG2+1:2] ^ history_q;
`else
    assign pred_idx = predict_pc_in[ENTRIES_LOG2+1:2];
    assign upd_idx  = update_pc_in[ENTRIES_LOG2+1:2];
`endif

    assign upd_cur = counter_q[upd_idx];

    sat_counter2 u_sat_counter2 (
        .value      (upd_cur),
        .taken      (update_taken_in),
        .next_value (upd_next)
    );

    // Control state, init walk and registered prediction outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BP_STATE_INIT;
            idx_q        <= '0;
            ready_q      <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            // Table read happens before this edge's write: no bypass.
            pred_valid_q <= run && predict_valid_in;
            pred_taken_q <= run && predict_valid_in && counter_q[pred_idx][1];
            if (state_q == BP_STATE_INIT) begin
                idx_q <= idx_q + ENTRIES_LOG2'(1);
                if (&idx_q) begin
                    state_q <= BP_STATE_RUN;
                    ready_q <= 1'b1;
                end
            end
        end
    end

    // Counter table: init writes during the walk, training writes in run.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == BP_STATE_INIT) begin
                counter_q[idx_q] <= RESET_COUNTER;
            end else if (update_valid_in) begin
                counter_q[upd_idx] <= upd_next;
            end
        end
    end

    assign ready_out         = ready_q;
    assign predict_valid_out = pred_valid_q;
    assign predict_taken_out = pred_taken_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, compared against a behavioural table model.
module tb_branch_predictor;

    localparam int LOG2  = 6;
    localparam int DEPTH = 64;
    localparam int INIT_CYCLES = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready_out;
    logic        predict_valid_in;
    logic [31:0] predict_pc_in;
    logic        predict_valid_out;
    logic        predict_taken_out;
    logic        update_valid_in;
    logic [31:0] update_pc_in;
    logic        update_taken_in;

    branch_predictor #(
        .ENTRIES_LOG2  (LOG2),
        .RESET_COUNTER (2'b01)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ready_out         (ready_out),
        .predict_valid_in  (predict_valid_in),
        .predict_pc_in     (predict_pc_in),
        .predict_valid_out (predict_valid_out),
        .predict_taken_out (predict_taken_out),
        .update_valid_in   (update_valid_in),
        .update_pc_in      (update_pc_in),
        .update_taken_in   (update_taken_in)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: counter values as plain integers 0..3.
    int m_tab [DEPTH];
    int m_init_left = 0;
    int m_hist = 0;
    int exp_ready, exp_pv, exp_pt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_index(input logic [31:0] pc);
        return ((int'(pc) >> 2) % DEPTH) ^ m_hist;
    endfunction

    // One clock: drive inputs, predict with the model, then compare outputs.
    task automatic step(input logic rst, input logic pv, input logic [31:0] ppc,
                        input logic uv, input logic [31:0] upc, input logic ut);
        int pi, ui;
        reset            = rst;
        predict_valid_in = pv;
        predict_pc_in    = ppc;
        update_valid_in  = uv;
        update_pc_in     = upc;
        update_taken_in  = ut;
        if (rst) begin
            m_init_left = INIT_CYCLES;
            m_hist      = 0;
            exp_ready   = 0;
            exp_pv      = 0;
            exp_pt      = 0;
        end else if (m_init_left > 0) begin
            m_init_left--;
            exp_pv = 0;
            exp_pt = 0;
            exp_ready = (m_init_left == 0) ? 1 : 0;
            if (m_init_left == 0) begin
                for (int i = 0; i < DEPTH; i++) m_tab[i] = 1;
            end
        end else begin
            pi = model_index(ppc);
            ui = model_index(upc);
            exp_ready = 1;
            exp_pv = pv ? 1 : 0;
            exp_pt = (pv && m_tab[pi] >= 2) ? 1 : 0;
            if (uv) begin
                if (ut) m_tab[ui] = (m_tab[ui] == 3) ? 3 : m_tab[ui] + 1;
                else    m_tab[ui] = (m_tab[ui] == 0) ? 0 : m_tab[ui] - 1;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
                m_hist = ((m_hist << 1) | (ut ? 1 : 0)) % DEPTH;
`endif
            end
        end
        @(posedge clk);
        #1;
        check_eq("ready_out", {31'd0, ready_out}, exp_ready);
        check_eq("predict_valid_out", {31'd0, predict_valid_out}, exp_pv);
        check_eq("predict_taken_out", {31'd0, predict_taken_out}, exp_pt);
    endtask

    task automatic do_reset_and_init();
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        // Requests during init must be ignored.
        for (int i = 0; i < INIT_CYCLES; i++) begin
            step(1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1);
        end
    endtask

    task automatic predict_only(input logic [31:0] pc);
        step(1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic train(input logic [31:0] pc, input logic taken);
        step(1'b0, 1'b0, 32'h0, 1'b1, pc, taken);
    endtask

    // Directed spot checks against constants (pure PC indexing only).
    task automatic expect_taken(input string tag, input logic exp);
`ifndef BRANCH_PREDICTOR_GSHARE_EN
        check_eq(tag, {31'd0, predict_taken_out}, {31'd0, exp});
`endif
    endtask

    logic [31:0] pool [8];

    initial begin
        reset = 1'b0;
        predict_valid_in = 1'b0;
        predict_pc_in = '0;
        update_valid_in = 1'b0;
        update_pc_in = '0;
        update_taken_in = 1'b0;
        @(negedge clk);

        do_reset_and_init();
        predict_only(32'h100);
        expect_taken("cold_0x100", 1'b0);

        // Training and saturation on 0x100.
        train(32'h100, 1'b1);
        predict_only(32'h100);
        expect_taken("train_10", 1'b1);
        train(32'h100, 1'b1);
        train(32'h100, 1'b1);
        train(32'h100, 1'b0);
        predict_only(32'h100);
        expect_taken("sat_11_to_10", 1'b1);
        for (int i = 0; i < 3; i++) train(32'h100, 1'b0);
        predict_only(32'h100);
        expect_taken("down_to_00", 1'b0);
        train(32'h100, 1'b0);
        train(32'h100, 1'b1);
        predict_only(32'h100);
        expect_taken("floor_00_then_01", 1'b0);

        // Aliasing: 0x200 shares 0x100's entry, 0x104 does not.
        do_reset_and_init();
        for (int i = 0; i < 3; i++) train(32'h100, 1'b1);
        predict_only(32'h200);
        expect_taken("alias_0x200", 1'b1);
        predict_only(32'h104);
        expect_taken("alias_0x104", 1'b0);

        // Same-cycle predict and update: read-before-write.
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1);
        expect_taken("collide_pre", 1'b0);
        predict_only(32'h40);
        expect_taken("collide_post", 1'b1);

        // Mid-run reset restarts the walk.
        for (int i = 0; i < 3; i++) train(32'h100, 1'b1);
        do_reset_and_init();
        predict_only(32'h100);
        expect_taken("after_rerun_init", 1'b0);

        // Randomized traffic with a small PC pool to force hits and aliases.
        for (int i = 0; i < 8; i++) pool[i] = $urandom() & 32'h0000_03fc;
        pool[0] = 32'h100;
        pool[1] = 32'h200;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)] | ($urandom() & 32'hffff_f003),
                 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)] | ($urandom() & 32'hffff_f003),
                 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
